// File: rtl/alu_pkg.sv
// Shared constants for the RV32I ALU: datapath width and ALUControl encodings.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/alu_shifter.sv
// Five-level logical barrel shifter; left_i selects SLL, otherwise SRL.
import alu_pkg::*;

module alu_shifter (
    input  logic [XLEN-1:0] data_i,
    input  logic [4:0]      shamt_i,
    input  logic            left_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] stg [0:5];

    always_comb begin
        stg[0] = data_i;
        for (int k = 0; k < 5; k++) begin
            if (!shamt_i[k])
                stg[k+1] = stg[k];
            else if (left_i)
                stg[k+1] = stg[k] << (1 << k);
            else
                stg[k+1] = stg[k] >> (1 << k);
        end
    end

    assign data_o = stg[5];

endmodule

// File: rtl/alu_core.sv
// RV32I ALU with combinational result/Zero and registered copies.
// Define ALU_CORE_FLAGS_EN to add Carry/Overflow/Negative outputs.
import alu_pkg::*;

module alu_core (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic [2:0]      ALUControl,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero,
    output logic [XLEN-1:0] ResultQ,
    output logic            ZeroQ
`ifdef ALU_CORE_FLAGS_EN
    ,
    output logic            Carry,
    output logic            Overflow,
    output logic            Negative
`endif
);

    logic            sub;
    logic [XLEN-1:0] b_eff;
    logic [XLEN-1:0] sum;
    logic            ovf;
    logic            slt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] result_d;
    logic            zero_d;
    logic [XLEN-1:0] result_q;
    logic            zero_q;

    // SUB and SLT share the adder through ~B with carry-in 1
    assign sub   = (ALUControl == ALU_SUB) || (ALUControl == ALU_SLT);
    assign b_eff = sub ? ~SrcB : SrcB;

`ifdef ALU_CORE_FLAGS_EN
    logic carry;
    assign {carry, sum} = {1'b0, SrcA} + {1'b0, b_eff} + (XLEN+1)'(sub);
`else
    assign sum = SrcA + b_eff + XLEN'(sub);
`endif

    assign ovf = (SrcA[XLEN-1] ~^ b_eff[XLEN-1])
               & (SrcA[XLEN-1] ^ sum[XLEN-1]);
    assign slt = sum[XLEN-1] ^ ovf;

    alu_shifter u_shifter (
        .data_i  (SrcA),
        .shamt_i (SrcB[4:0]),
        .left_i  (ALUControl == ALU_SLL),
        .data_o  (shifted)
    );

    always_comb begin
        result_d = '0;
        case (ALUControl)
            ALU_ADD: result_d = sum;
            ALU_SUB: result_d = sum;
            ALU_AND: result_d = SrcA & SrcB;
            ALU_OR:  result_d = SrcA | SrcB;
            ALU_XOR: result_d = SrcA ^ SrcB;
            ALU_SLL: result_d = shifted;
            ALU_SRL: result_d = shifted;
            ALU_SLT: result_d = {{(XLEN-1){1'b0}}, slt};
            default: result_d = '0;
        endcase
    end

    assign zero_d    = (result_d == '0);
    assign ALUResult = result_d;
    assign Zero      = zero_d;

`ifdef ALU_CORE_FLAGS_EN
    logic arith;
    assign arith    = (ALUControl == ALU_ADD) || (ALUControl == ALU_SUB);
    assign Carry    = arith & carry;
    assign Overflow = arith & ovf;
    assign Negative = result_d[XLEN-1];
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q <= '0;
            zero_q   <= 1'b1;
        end else begin
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign ResultQ = result_q;
    assign ZeroQ   = zero_q;

endmodule

// File: tb/tb_alu_core.sv
// Scoreboard bench for alu_core: driver queues expectations, monitor checks.
import alu_pkg::*;

module tb_alu_core;

    logic        clk;
    logic        reset;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic [2:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        Zero;
    logic [31:0] ResultQ;
    logic        ZeroQ;
`ifdef ALU_CORE_FLAGS_EN
    logic        Carry;
    logic        Overflow;
    logic        Negative;
`endif

    alu_core dut (
        .clk        (clk),
        .reset      (reset),
        .SrcA       (SrcA),
        .SrcB       (SrcB),
        .ALUControl (ALUControl),
        .ALUResult  (ALUResult),
        .Zero       (Zero),
        .ResultQ    (ResultQ),
        .ZeroQ      (ZeroQ)
`ifdef ALU_CORE_FLAGS_EN
        ,
        .Carry      (Carry),
        .Overflow   (Overflow),
        .Negative   (Negative)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ctrl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        string       name;
    } vec_t;

    vec_t        exp_q[$];
    int          checks = 0;
    int          passed = 0;
    bit          have_prev = 0;
    logic [31:0] prev_res;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act === req)
            passed++;
        else
            $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic drive(input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r,
                         input string n);
        vec_t v;
        @(posedge clk);
        #2;
        SrcA       = a;
        SrcB       = b;
        ALUControl = c;
        v.ctrl = c; v.a = a; v.b = b; v.res = r; v.name = n;
        exp_q.push_back(v);
    endtask

    // Registered path lags the combinational check by one cycle
    always @(negedge clk) begin
        vec_t v;
        if (reset) begin
            check("rst_ResultQ", ResultQ, 32'h0);
            check("rst_ZeroQ", {31'b0, ZeroQ}, 32'h1);
            have_prev = 0;
        end else if (have_prev) begin
            check("ResultQ", ResultQ, prev_res);
            check("ZeroQ", {31'b0, ZeroQ}, {31'b0, prev_res == 32'h0});
            have_prev = 0;
        end
        if (exp_q.size() > 0) begin
            v = exp_q.pop_front();
            check(v.name, ALUResult, v.res);
            check({v.name, "_zero"}, {31'b0, Zero}, {31'b0, v.res == 32'h0});
`ifdef ALU_CORE_FLAGS_EN
            check({v.name, "_neg"}, {31'b0, Negative}, {31'b0, v.res[31]});
`endif
            prev_res  = v.res;
            have_prev = 1;
        end
    end

    initial begin
        reset      = 1'b1;
        SrcA       = '0;
        SrcB       = '0;
        ALUControl = ALU_ADD;
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        drive(ALU_ADD, 32'd10, 32'd5, 32'd15, "add");
        drive(ALU_SUB, 32'd10, 32'd10, 32'd0, "sub_zero");
        drive(ALU_AND, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, "and");
        drive(ALU_OR, 32'hAAAA5555, 32'h5555AAAA, 32'hFFFFFFFF, "or");
        drive(ALU_XOR, 32'h12345678, 32'h87654321, 32'h95511559, "xor");
        drive(ALU_SLL, 32'd1, 32'd3, 32'd8, "sll");
        drive(ALU_SRL, 32'd8, 32'd2, 32'd2, "srl");
        drive(ALU_SLT, 32'd5, 32'd10, 32'd1, "slt_lt");
        drive(ALU_SLT, 32'd10, 32'd5, 32'd0, "slt_ge");
        drive(ALU_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, "slt_neg");
        drive(ALU_SRL, 32'h80000000, 32'd31, 32'd1, "srl_logical");
        drive(ALU_SLT, 32'h80000000, 32'h7FFFFFFF, 32'd1, "slt_min_max");
        drive(ALU_SLT, 32'h7FFFFFFF, 32'h80000000, 32'd0, "slt_max_min");
        drive(ALU_SLL, 32'd1, 32'hFFFFFFE3, 32'd8, "sll_hi_ignored");
        drive(ALU_SLL, 32'd1, 32'd31, 32'h80000000, "sll_31");
        drive(ALU_ADD, 32'hFFFFFFFF, 32'd1, 32'd0, "add_wrap");
        drive(ALU_SUB, 32'd0, 32'd1, 32'hFFFFFFFF, "sub_wrap");
        drive(3'bxxx, 32'd0, 32'd0, 32'd0, "default_x");
        drive(ALU_OR, 32'h00000001, 32'h00000002, 32'd3, "pre_reset");

        // Asynchronous reset mid-cycle, away from any clock edge
        #1 reset = 1'b1;
        #1;
        check("async_ResultQ", ResultQ, 32'h0);
        check("async_ZeroQ", {31'b0, ZeroQ}, 32'h1);
        check("comb_in_reset", ALUResult, 32'd3);
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;

        drive(ALU_ADD, 32'd10, 32'd5, 32'd15, "add_after_reset");
        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d left, expected 0",
                     exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/alu_core.md
# alu_core

32-bit integer ALU for the RV32I datapath, driven by the decoder's 3-bit ALUControl. It computes add, subtract, bitwise logic, shifts and signed set-less-than. The result and Zero flag are combinational for same-cycle use in the execute stage. Clocked copies of the result and flag are also provided for pipelined consumers.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  rising-edge clock for registered outputs.
- reset  in  1  asynchronous, active-high; clears registered outputs.
- SrcA  in  32  operand A.
- SrcB  in  32  operand B; shift amount is SrcB[4:0].
- ALUControl  in  3  operation select.
- ALUResult  out  32  combinational result.
- Zero  out  1  combinational, 1 when ALUResult == 0.
- ResultQ  out  32  ALUResult registered on clk.
- ZeroQ  out  1  Zero registered on clk.
- Carry, Overflow, Negative  out  1 each  combinational flags; present only with ALU_CORE_FLAGS_EN.

## Operation
- 000 ADD: SrcA + SrcB, modulo 2^32.
- 001 SUB: SrcA − SrcB, modulo 2^32.
- 010 AND: bitwise.
- 011 OR: bitwise.
- 100 XOR: bitwise.
- 101 SLL: SrcA << SrcB[4:0], zero fill. SrcB[31:5] is ignored.
- 110 SRL: SrcA >> SrcB[4:0], logical, zero fill.
- 111 SLT: 32'd1 if $signed(SrcA) < $signed(SrcB), else 0.
- Any other ALUControl value, including X or Z: ALUResult = 0, so Zero = 1. The default branch is mandatory and no latches are allowed.
- Zero always tracks ALUResult, including in the default case.
- SLT is computed from the subtractor's sign bit XOR signed overflow. It must be correct at extremes, e.g. 0x80000000 < 0x7FFFFFFF gives 1.

## Timing
- ALUResult and Zero are purely combinational, with zero latency.
- ResultQ and ZeroQ capture ALUResult and Zero on every rising clk edge, giving 1-cycle latency. There is no enable.
- Reset asserted, asynchronously and at any time including mid-operation: ResultQ = 0 and ZeroQ = 1, held while reset stays high.
- The first capture happens at the first rising edge after reset deasserts.
- Reset does not affect the combinational outputs.

## Configuration
- ALU_CORE_FLAGS_EN defined: Carry, Overflow and Negative ports exist.
  - Carry = carry-out of ADD, or NOT borrow for SUB; 0 for other operations.
  - Overflow = signed overflow of ADD/SUB; 0 for other operations.
  - Negative = ALUResult[31].
- ALU_CORE_FLAGS_EN undefined: those ports and their logic are absent. All other behaviour is identical.

## Structure
- Package alu_pkg holds ALUControl localparams: ALU_ADD = 3'b000, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SLT = 3'b111. It also holds the XLEN = 32 constant.
- One sub-module, alu_shifter: combinational left/right logical barrel shifter, 5-level, taking a direction select.
- Adder and subtractor share one adder, using an inverted B plus carry-in.

## Test plan
- ADD: SrcA=10, SrcB=5, ctrl=000 -> ALUResult=15, Zero=0.
- SUB and Zero: SrcA=10, SrcB=10, ctrl=001 -> 0, Zero=1.
- Logic ops:
  - 0xF0F0F0F0 AND 0x0F0F0F0F -> 0, Zero=1.
  - 0xAAAA5555 OR 0x5555AAAA -> 0xFFFFFFFF.
  - 0x12345678 XOR 0x87654321 -> 0x95511559.
- Shifts and SLT:
  - 1 SLL 3 -> 8.
  - 8 SRL 2 -> 2.
  - SLT 5,10 -> 1; SLT 10,5 -> 0.
  - SLT 0xFFFFFFFF,1 -> 1.
  - 0x80000000 SRL 31 -> 1 (logical).
- Default: ctrl=3'bxxx, SrcA=SrcB=0 -> ALUResult=0, Zero=1.
- Registered path:
  - Assert reset mid-stream -> ResultQ=0, ZeroQ=1 immediately, without waiting for clk.
  - Release reset, apply ADD 10+5 -> ResultQ=15 and ZeroQ=0 after the next rising edge.
